// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter, presents the word address to the instruction
// cache controller, captures returned words into an in-order queue for
// decode, and handles branch redirect, including squashing an in-flight miss.
// Optional feature macro: FETCH_PERF_EN adds perf_miss_cycles/perf_fetched.
module fetch_unit #(
  parameter int          QDEPTH   = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [15:0]               i_addr,
  input  logic [15:0]               instr,
  input  logic                      instr_rdy,
  input  logic                      redirect,
  input  logic [15:0]               redirect_pc,
  input  logic                      halt,
  output logic [15:0]               dec_instr,
  output logic [15:0]               dec_pc,
  output logic                      dec_valid,
  input  logic                      dec_ready,
`ifdef FETCH_PERF_EN
  output logic [15:0]               perf_miss_cycles,
  output logic [15:0]               perf_fetched,
`endif
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     pc_q, pc_d;
  logic [15:0]     tgt_q, tgt_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            head_valid_s;
  logic            pop_s;
  logic            push_s;

  // Queue storage: instruction word and its PC per entry, never reset.
  logic [15:0]     mem_instr [QDEPTH];
  logic [15:0]     mem_pc    [QDEPTH];

  // Next-state logic: FSM, PC, redirect target and queue pointers.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    push_s   = 1'b0;

    // Redirect hides the head so decode can never pop an entry being flushed.
    head_valid_s = (count_q != {CW{1'b0}}) && !redirect;
    pop_s        = head_valid_s && dec_ready;

    case (state_q)
      RUN: begin
        if (redirect) begin
          if (instr_rdy) begin
            pc_d = redirect_pc;
          end else begin
            // A miss is in flight: keep the address steady until the fill.
            tgt_d   = redirect_pc;
            state_d = SQUASH;
          end
        end else begin
          if (instr_rdy && !halt && ((count_q < QFULL) || pop_s)) begin
            push_s = 1'b1;
            pc_d   = pc_q + 16'd1;
          end else begin
            push_s = 1'b0;
          end
        end
      end
      SQUASH: begin
        if (redirect) begin
          tgt_d = redirect_pc;
        end else if (instr_rdy) begin
          // Fill word for the abandoned address is discarded here.
          pc_d    = tgt_q;
          state_d = RUN;
        end else begin
          state_d = SQUASH;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (redirect) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s && !pop_s) begin
        count_d = count_q + CW'(1);
      end else if (pop_s && !push_s) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // State, PC and queue-control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      tgt_q    <= 16'h0000;
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage write on capture.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_instr[wr_ptr_q] <= instr;
      mem_pc[wr_ptr_q]    <= pc_q;
    end
  end

  // Output drive: address straight from the PC register, head zeroed when invalid.
  always_comb begin
    i_addr    = pc_q;
    q_count   = count_q;
    dec_valid = head_valid_s;
    if (head_valid_s) begin
      dec_instr = mem_instr[rd_ptr_q];
      dec_pc    = mem_pc[rd_ptr_q];
    end else begin
      dec_instr = 16'h0000;
      dec_pc    = 16'h0000;
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] miss_q, miss_d;
  logic [15:0] fet_q, fet_d;

  // Performance counter next values: saturating miss cycles, wrapping captures.
  always_comb begin
    miss_d = miss_q;
    fet_d  = fet_q;
    if (!instr_rdy && (miss_q != 16'hFFFF)) begin
      miss_d = miss_q + 16'd1;
    end else begin
      miss_d = miss_q;
    end
    if (push_s) begin
      fet_d = fet_q + 16'd1;
    end else begin
      fet_d = fet_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_q <= 16'h0000;
      fet_q  <= 16'h0000;
    end else begin
      miss_q <= miss_d;
      fet_q  <= fet_d;
    end
  end

  assign perf_miss_cycles = miss_q;
  assign perf_fetched     = fet_q;
`else
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_unit;

  localparam int          QDEPTH   = 4;
  localparam logic [15:0] RESET_PC = 16'h0100;

  logic        clk;
  logic        rst;
  logic [15:0] i_addr;
  logic [15:0] instr;
  logic        instr_rdy;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [2:0]  q_count;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_miss_cycles;
  logic [15:0] perf_fetched;
`endif

  // Cache stand-in: always hit in hit mode, else only the fill pulse.
  logic mode_hit;
  logic fill_pulse;

  int checks;
  int errors;

  fetch_unit #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .instr(instr),
    .instr_rdy(instr_rdy), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
`ifdef FETCH_PERF_EN
    .perf_miss_cycles(perf_miss_cycles), .perf_fetched(perf_fetched),
`endif
    .q_count(q_count)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  assign instr_rdy = mode_hit | fill_pulse;
  assign instr     = mem_word(i_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_pc;
  logic [15:0] m_tgt;
  bit          m_squash;
  logic [31:0] mq[$];
  logic [15:0] m_miss;
  logic [15:0] m_fet;

  // Compare process: check outputs against the model, then advance the model
  always @(negedge clk) begin
    bit          exp_valid;
    bit          pop;
    bit          cap;
    logic [31:0] head;
    #3;
    if (rst) begin
      m_pc = RESET_PC; m_tgt = 16'h0000; m_squash = 0; mq.delete();
      m_miss = 16'h0000; m_fet = 16'h0000;
      chk("rst_i_addr", {16'h0, i_addr}, {16'h0, RESET_PC});
      chk("rst_dec_valid", {31'h0, dec_valid}, 32'h0);
      chk("rst_q_count", {29'h0, q_count}, 32'h0);
      chk("rst_dec_pc", {16'h0, dec_pc}, 32'h0);
    end else begin
      exp_valid = (mq.size() > 0) && !redirect;
      head = exp_valid ? mq[0] : 32'h0;
      chk("i_addr", {16'h0, i_addr}, {16'h0, m_pc});
      chk("dec_valid", {31'h0, dec_valid}, {31'h0, exp_valid});
      chk("dec_instr", {16'h0, dec_instr}, {16'h0, head[31:16]});
      chk("dec_pc", {16'h0, dec_pc}, {16'h0, head[15:0]});
      chk("q_count", {29'h0, q_count}, mq.size());
`ifdef FETCH_PERF_EN
      chk("perf_miss", {16'h0, perf_miss_cycles}, {16'h0, m_miss});
      chk("perf_fetched", {16'h0, perf_fetched}, {16'h0, m_fet});
`endif
      pop = exp_valid && dec_ready;
      if (redirect) begin
        mq.delete();
        if (m_squash) m_tgt = redirect_pc;
        else if (instr_rdy) m_pc = redirect_pc;
        else begin m_tgt = redirect_pc; m_squash = 1; end
      end else if (m_squash) begin
        if (instr_rdy) begin m_pc = m_tgt; m_squash = 0; end
      end else begin
        cap = instr_rdy && !halt && ((mq.size() < QDEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (cap) begin
          mq.push_back({mem_word(m_pc), m_pc});
          m_pc  = m_pc + 16'd1;
          m_fet = m_fet + 16'd1;
        end
      end
      if (!instr_rdy && m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
    end
  end

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; mode_hit = 1'b1;
    fill_pulse = 1'b0; dec_ready = rdy;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
`ifdef FETCH_PERF_EN
    logic [15:0] fet_snap;
`endif
    checks = 0; errors = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    mode_hit = 1'b1; fill_pulse = 1'b0; dec_ready = 1'b1;

    // Hit stream from RESET_PC, decode always ready
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    #4;
    chk("lit_stream_addr", {16'h0, i_addr}, 32'h0103);
    chk("lit_stream_pc", {16'h0, dec_pc}, 32'h0102);

    // Decode stalled: fill to QDEPTH, then push+pop at full
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    dec_ready = 1'b1;
    #4;
    chk("lit_full_addr", {16'h0, i_addr}, 32'h0104);
    chk("lit_full_cnt", {29'h0, q_count}, 32'd4);
    chk("lit_full_head", {16'h0, dec_pc}, 32'h0100);
    @(negedge clk); #4;
    chk("lit_pp_cnt", {29'h0, q_count}, 32'd4);
    chk("lit_pp_addr", {16'h0, i_addr}, 32'h0105);
    chk("lit_pp_head", {16'h0, dec_pc}, 32'h0101);

    // Miss at 0200, redirect to 0300 in miss cycle 2, 5-cycle fill
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0200;
    @(negedge clk); redirect = 1'b0; mode_hit = 1'b0;
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0300; #4;
    chk("lit_sq_addr2", {16'h0, i_addr}, 32'h0200);
    @(negedge clk); redirect = 1'b0; #4;
    chk("lit_sq_addr3", {16'h0, i_addr}, 32'h0200);
    chk("lit_sq_cnt3", {29'h0, q_count}, 32'd0);
    @(negedge clk); #4;
    chk("lit_sq_addr4", {16'h0, i_addr}, 32'h0200);
    @(negedge clk); fill_pulse = 1'b1; #4;
    chk("lit_sq_addr5", {16'h0, i_addr}, 32'h0200);
    chk("lit_sq_cnt5", {29'h0, q_count}, 32'd0);
    @(negedge clk); fill_pulse = 1'b0; mode_hit = 1'b1; #4;
    chk("lit_sq_tgt", {16'h0, i_addr}, 32'h0300);
    chk("lit_sq_nofill", {29'h0, q_count}, 32'd0);
    @(negedge clk); dec_ready = 1'b0; #4;
    chk("lit_tgt_head", {16'h0, dec_pc}, 32'h0300);

    // Redirect on a hit cycle with three queued entries
    repeat (2) @(negedge clk);
    redirect = 1'b1; redirect_pc = 16'h0040; #4;
    chk("lit_rd_valid", {31'h0, dec_valid}, 32'd0);
    chk("lit_rd_cnt", {29'h0, q_count}, 32'd3);
    @(negedge clk); redirect = 1'b0; dec_ready = 1'b1; #4;
    chk("lit_rd_addr", {16'h0, i_addr}, 32'h0040);
    chk("lit_rd_flush", {29'h0, q_count}, 32'd0);

    // PC wrap FFFF -> 0000
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk); redirect = 1'b0; #4;
    chk("lit_wrap_ffff", {16'h0, i_addr}, 32'hFFFF);
    @(negedge clk); #4;
    chk("lit_wrap_0000", {16'h0, i_addr}, 32'h0000);
    chk("lit_wrap_head", {16'h0, dec_pc}, 32'hFFFF);
    @(negedge clk); #4;
    chk("lit_wrap_head2", {16'h0, dec_pc}, 32'h0000);

    // Halt for 3 cycles with 2 queued: queue drains, address holds
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0500; dec_ready = 1'b0;
    @(negedge clk); redirect = 1'b0;
    @(negedge clk);
    @(negedge clk); halt = 1'b1; dec_ready = 1'b1; #4;
    chk("lit_halt_cnt0", {29'h0, q_count}, 32'd2);
    chk("lit_halt_addr0", {16'h0, i_addr}, 32'h0502);
`ifdef FETCH_PERF_EN
    fet_snap = perf_fetched;
`endif
    @(negedge clk); #4;
    chk("lit_halt_cnt1", {29'h0, q_count}, 32'd1);
    @(negedge clk); #4;
    chk("lit_halt_cnt2", {29'h0, q_count}, 32'd0);
    @(negedge clk); halt = 1'b0; #4;
    chk("lit_halt_cnt3", {29'h0, q_count}, 32'd0);
    chk("lit_halt_addr3", {16'h0, i_addr}, 32'h0502);
`ifdef FETCH_PERF_EN
    chk("lit_halt_perf", {16'h0, perf_fetched}, {16'h0, fet_snap});
`endif

    // Plain miss at 0503 with fill captured on the pulse
    @(negedge clk); mode_hit = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk); fill_pulse = 1'b1;
    @(negedge clk); fill_pulse = 1'b0; mode_hit = 1'b1; #4;
    chk("lit_miss_addr", {16'h0, i_addr}, 32'h0504);
    chk("lit_miss_head", {16'h0, dec_pc}, 32'h0503);

    // Reset while squashing abandons the squash
    @(negedge clk); redirect = 1'b1; redirect_pc = 16'h0700; mode_hit = 1'b0;
    @(negedge clk); redirect = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; mode_hit = 1'b1; #4;
    chk("lit_rst_sq_addr", {16'h0, i_addr}, 32'h0100);
    @(negedge clk); #4;
    chk("lit_rst_sq_next", {16'h0, i_addr}, 32'h0101);

    repeat (4) @(negedge clk);
    #4;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction cache controller. Owns the program counter and drives the 16-bit word address into the cache controller. Captures each returned instruction when `instr_rdy` is high and buffers it, with its PC, in a small in-order queue for decode. Supports branch redirect with correct squashing of an in-flight miss, plus an external halt.

## Interface
Parameters:
- `QDEPTH`, 4: instruction queue entries; power of two, 2..16.
- `RESET_PC`, 16'h0000: PC loaded on reset.

Ports:
- `clk`  input  1  sole clock; all state changes on posedge.
- `rst`  input  1  asynchronous, active-high reset.
- `i_addr`  output  16  word address to cache controller; `[15:2]` = line, `[1:0]` = word in line.
- `instr`  input  16  instruction word from cache controller.
- `instr_rdy`  input  1  `instr` valid for `i_addr` this cycle. Combinational on a hit; one-cycle pulse at miss fill.
- `redirect`  input  1  branch/exception redirect, single-cycle.
- `redirect_pc`  input  16  target PC, sampled when `redirect`=1.
- `halt`  input  1  suppress capture while high.
- `dec_instr`  output  16  queue head instruction.
- `dec_pc`  output  16  queue head PC.
- `dec_valid`  output  1  queue head valid.
- `dec_ready`  input  1  decode accepts head; a transfer occurs when `dec_valid & dec_ready`.
- `q_count`  output  log2(QDEPTH)+1  current queue occupancy.

## Operation
- State machine: RUN, SQUASH.
- **RUN**
  - `i_addr` = `pc`.
  - Capture when `instr_rdy & ~halt & ~redirect & (q_count<QDEPTH | pop)`.
  - Capture pushes {`instr`, `pc`} and sets `pc <= pc+1`.
  - PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000.
- **Address stability rule:** `i_addr` must not change while `instr_rdy`=0, because the cache controller's memory address follows `i_addr` during a miss. `pc` changes only on a capture cycle or a redirect cycle with `instr_rdy`=1.
- **Redirect (priority over everything)**
  - The queue is flushed (count to 0) in the redirect cycle.
  - `dec_valid` is forced to 0 combinationally during `redirect`, so no pop occurs.
  - If `instr_rdy`=1 that cycle: `pc <= redirect_pc`, nothing captured, remain RUN.
  - If `instr_rdy`=0 (miss outstanding): latch `redirect_pc` into `tgt`, go to SQUASH.
- **SQUASH**
  - `i_addr` holds the old `pc`; no capture.
  - When `instr_rdy`=1: discard the word, set `pc <= tgt`, go to RUN.
  - A further `redirect` in SQUASH overwrites `tgt` and flushes again; it does not exit SQUASH.
- **Halt:** blocks capture only. PC holds; the queue still drains to decode; redirect still acts.
- **Queue**
  - Circular buffer with wrapping read/write pointers.
  - Push and pop in the same cycle are allowed when full; count is unchanged.
  - Pop when empty is impossible, because `dec_valid`=0.
  - `dec_instr`/`dec_pc` read 16'h0000 whenever `dec_valid`=0.
- **Reset (asynchronous):**
  - State RUN, `pc`=`RESET_PC`, `i_addr`=`RESET_PC`, `tgt`=0.
  - Pointers 0, `q_count`=0, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0, perf counters 0.
  - Storage array is not reset.
  - Reset mid-miss abandons the squash with no side effects.

## Timing
- Hit stream: one capture per cycle. A captured word appears at `dec_valid` the cycle after capture.
- Miss: `i_addr` held for N cycles until the fill pulse; capture occurs on the pulse edge.
- The new `i_addr` is presented the cycle after capture, redirect, or squash exit.
- Redirect-to-first-capture of the target:
  - 1 cycle on a hit when the redirect cycle had `instr_rdy`=1.
  - Otherwise 1 cycle after the squash completes.
- No combinational path from `instr`/`instr_rdy` to any output. `dec_valid` depends combinationally only on `redirect` and registered state.

## Configuration
- `FETCH_PERF_EN` defined: adds two output ports, `perf_miss_cycles` [15:0] and `perf_fetched` [15:0].
  - `perf_miss_cycles` counts cycles with `instr_rdy`=0 in either state; saturates at 16'hFFFF.
  - `perf_fetched` counts captures; wraps.
  - Both counters reset to 0.
- `FETCH_PERF_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset with `RESET_PC`=16'h0100, always-hit cache, `dec_ready`=1 -> `i_addr` sequence 0100,0101,0102…; `dec_pc` follows one cycle later; one instruction per cycle.
- `dec_ready`=0 with hits -> `q_count` reaches 4 and holds; `i_addr` freezes at 0104. Then `dec_ready`=1 -> push+pop each cycle, count stays 4.
- Miss at 0200 with a 5-cycle fill, `redirect` to 0300 in cycle 2 of the miss -> `i_addr` stays 0200 until the fill pulse; the fill word is not queued; next `i_addr`=0300; queue empty throughout.
- `redirect` to 0040 on a hit cycle with 3 queued entries -> `dec_valid`=0 that cycle, queue flushed; `i_addr`=0040 next cycle.
- PC at 16'hFFFF with hits -> captures FFFF then 0000.
- `halt`=1 for 3 cycles with 2 queued and `dec_ready`=1 -> the queue drains to 0 and `i_addr` is unchanged. With `FETCH_PERF_EN`, `perf_fetched` does not advance during `halt`.
